// File: rtl/ahb_err_slave.sv
// rtl/ahb_err_slave.sv - AHB default slave returning two-cycle ERROR responses with fault capture
module ahb_err_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  err_sel_i,
  input  logic [1:0]            HTRANS_i,
  input  logic [ADDR_WIDTH-1:0] HADDR_i,
  input  logic                  HWRITE_i,
  input  logic                  HREADY_i,
  output logic                  HREADYOUT_o,
  output logic                  HRESP_o,
  output logic [31:0]           HRDATA_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_write_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic                  irq_o,
  input  logic                  irq_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   ready_nxt;
  logic   resp_nxt;

  // ERR1 holds the bus stalled, so any select seen there belongs to a
  // transfer that has not yet reached its address phase and is ignored.
  assign accept = err_sel_i & HREADY_i & HTRANS_i[1] & (state != ST_ERR1);

  // Next state plus the response the bus sees while in that state.
  always_comb begin
    state_nxt = state;
    ready_nxt = 1'b1;
    resp_nxt  = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = accept ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    case (state_nxt)
      ST_ERR1: begin
        ready_nxt = 1'b0;
        resp_nxt  = 1'b1;
      end
      ST_ERR2: begin
        ready_nxt = 1'b1;
        resp_nxt  = 1'b1;
      end
      default: begin
        ready_nxt = 1'b1;
        resp_nxt  = 1'b0;
      end
    endcase
  end

  // State and bus response registers; outputs carry no path from inputs.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      HREADYOUT_o <= 1'b1;
      HRESP_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      HREADYOUT_o <= ready_nxt;
      HRESP_o     <= resp_nxt;
    end
  end

  // Fault capture: address, direction and a saturating count of faults.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      err_addr_o  <= '0;
      err_write_o <= 1'b0;
      err_cnt_o   <= '0;
    end else if (accept) begin
      err_addr_o  <= HADDR_i;
      err_write_o <= HWRITE_i;
      if (err_cnt_o != {CNT_WIDTH{1'b1}}) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  // Sticky interrupt; a new fault in the clearing cycle keeps it raised.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)       irq_o <= 1'b0;
    else if (accept)    irq_o <= 1'b1;
    else if (irq_clr_i) irq_o <= 1'b0;
  end

  assign HRDATA_o = 32'h0;

endmodule

// File: tb/tb_ahb_err_slave.sv
// tb/tb_ahb_err_slave.sv - directed self-checking bench for ahb_err_slave
module tb_ahb_err_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        err_sel_i;
  logic [1:0]  HTRANS_i;
  logic [31:0] HADDR_i;
  logic        HWRITE_i;
  logic        HREADY_i;
  logic        irq_clr_i;

  logic        ready, resp, ewr, irq;
  logic [31:0] rdata, eaddr;
  logic [15:0] cnt;

  logic        s_ready, s_resp, s_ewr, s_irq;
  logic [31:0] s_rdata, s_eaddr;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_err_slave dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .err_sel_i(err_sel_i), .HTRANS_i(HTRANS_i),
    .HADDR_i(HADDR_i), .HWRITE_i(HWRITE_i), .HREADY_i(HREADY_i),
    .HREADYOUT_o(ready), .HRESP_o(resp), .HRDATA_o(rdata),
    .err_addr_o(eaddr), .err_write_o(ewr), .err_cnt_o(cnt),
    .irq_o(irq), .irq_clr_i(irq_clr_i)
  );

  ahb_err_slave #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut_small (
    .HCLK(HCLK), .HRESETn(HRESETn), .err_sel_i(err_sel_i), .HTRANS_i(HTRANS_i),
    .HADDR_i(HADDR_i), .HWRITE_i(HWRITE_i), .HREADY_i(HREADY_i),
    .HREADYOUT_o(s_ready), .HRESP_o(s_resp), .HRDATA_o(s_rdata),
    .err_addr_o(s_eaddr), .err_write_o(s_ewr), .err_cnt_o(s_cnt),
    .irq_o(s_irq), .irq_clr_i(irq_clr_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic rdy);
    err_sel_i = sel;
    HTRANS_i  = tr;
    HADDR_i   = a;
    HWRITE_i  = wr;
    HREADY_i  = rdy;
  endtask

  task automatic chk_rsp(input string tag, input logic r, input logic e);
    chk({tag, ".ready"}, ready, r);
    chk({tag, ".resp"}, resp, e);
  endtask

  initial begin
    HRESETn   = 1'b0;
    irq_clr_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
    step();
    step();
    chk_rsp("rst", 1'b1, 1'b0);
    chk("rst.cnt", cnt, 0);
    chk("rst.irq", irq, 0);
    chk("rst.addr", eaddr, 0);
    chk("rst.wr", ewr, 0);
    chk("rst.rdata", rdata, 0);
    HRESETn = 1'b1;

    // single NONSEQ read
    drive(1'b1, 2'b10, 32'hF000_0000, 1'b0, 1'b1);
    step();
    chk_rsp("rd.err1", 1'b0, 1'b1);
    chk("rd.rdata", rdata, 0);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    step();
    chk_rsp("rd.err2", 1'b1, 1'b1);
    HREADY_i = 1'b1;
    step();
    chk_rsp("rd.idle", 1'b1, 1'b0);
    chk("rd.addr", eaddr, 32'hF000_0000);
    chk("rd.wr", ewr, 0);
    chk("rd.cnt", cnt, 1);
    chk("rd.irq", irq, 1);

    // back-to-back write 0xA0 then SEQ 0xA4 accepted in ERR2
    drive(1'b1, 2'b10, 32'hA0, 1'b1, 1'b1);
    step();
    chk_rsp("b2b.err1a", 1'b0, 1'b1);
    drive(1'b1, 2'b11, 32'hA4, 1'b1, 1'b0);
    step();
    chk_rsp("b2b.err2a", 1'b1, 1'b1);
    chk("b2b.cnt_mid", cnt, 2);
    chk("b2b.addr_mid", eaddr, 32'hA0);
    HREADY_i = 1'b1;
    step();
    chk_rsp("b2b.err1b", 1'b0, 1'b1);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    step();
    chk_rsp("b2b.err2b", 1'b1, 1'b1);
    HREADY_i = 1'b1;
    step();
    chk_rsp("b2b.idle", 1'b1, 1'b0);
    chk("b2b.addr", eaddr, 32'hA4);
    chk("b2b.wr", ewr, 1);
    chk("b2b.cnt", cnt, 3);

    // IDLE and BUSY with select asserted are not accepted
    drive(1'b1, 2'b00, 32'h55, 1'b0, 1'b1);
    step();
    chk_rsp("idl", 1'b1, 1'b0);
    chk("idl.cnt", cnt, 3);
    HTRANS_i = 2'b01;
    step();
    chk_rsp("busy", 1'b1, 1'b0);
    chk("busy.cnt", cnt, 3);
    chk("busy.addr", eaddr, 32'hA4);

    // irq clear alone, then clear colliding with a new fault
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
    irq_clr_i = 1'b1;
    step();
    chk("clr.alone", irq, 0);
    drive(1'b1, 2'b10, 32'hC0, 1'b0, 1'b1);
    step();
    chk("clr.setwins", irq, 1);
    irq_clr_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    step();
    HREADY_i = 1'b1;
    step();
    chk("clr.hold", irq, 1);
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    chk("clr.later", irq, 0);

    // 13 more faults: 17 total, narrow counter saturates at 0xF
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 2'b10, 32'h100 + i, 1'b0, 1'b1);
      step();
      drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
      step();
      HREADY_i = 1'b1;
      step();
    end
    chk("sat.wide", cnt, 17);
    chk("sat.narrow", s_cnt, 4'hF);
    chk("sat.addr", eaddr, 32'h10C);

    // reset asserted during ERR1 wins over a fault and irq clear
    drive(1'b1, 2'b10, 32'hDEAD, 1'b1, 1'b1);
    step();
    chk_rsp("rerr.err1", 1'b0, 1'b1);
    HRESETn   = 1'b0;
    irq_clr_i = 1'b1;
    HREADY_i  = 1'b1;
    HTRANS_i  = 2'b10;
    step();
    chk_rsp("rerr", 1'b1, 1'b0);
    chk("rerr.cnt", cnt, 0);
    chk("rerr.irq", irq, 0);
    chk("rerr.addr", eaddr, 0);
    HRESETn   = 1'b1;
    irq_clr_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
    step();
    chk_rsp("rerr.after", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
